serial_subtractor_3bit: RTL and testbench
=========================================

# serial_subtractor_3bit

Bit-serial unsigned subtractor with borrow-in and borrow-out. It is the inverse of the combinational 3-bit adder: diff = a − b − bin (mod 2^WIDTH). It accepts one operand set through a valid/ready handshake, resolves one bit per clock LSB-first, and holds the result under output backpressure. It sits between an operand source and a result consumer that both use valid/ready streaming.

## Interface
- WIDTH, default 3: operand and result width in bits (≥1).
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  source presents a, b, bin.
- in_ready  output  1  block can accept an operand set (high only in IDLE).
- a  input  WIDTH  minuend, unsigned.
- b  input  WIDTH  subtrahend, unsigned.
- bin  input  1  borrow-in.
- out_valid  output  1  diff/bout valid (high only in DONE).
- out_ready  input  1  consumer accepts result.
- diff  output  WIDTH  (a − b − bin) mod 2^WIDTH.
- bout  output  1  borrow-out: 1 iff a < b + bin (unsigned, WIDTH+1-bit compare).
- busy  output  1  high in CALC or DONE.

## Operation
- FSM states are IDLE, CALC and DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, capture a, b and bin into internal shift registers, clear the bit counter, and go to CALC.
- CALC:
  - Each edge processes bit i = counter, starting at i=0.
  - Bit result: d_i = a_i ^ b_i ^ br.
  - Borrow update: br ← (~a_i & b_i) | (~(a_i ^ b_i) & br), with br initialised to bin.
  - On the edge processing i = WIDTH−1, load diff with the assembled bits, load bout with the final br, and go to DONE.
  - a, b, bin and in_valid are ignored during CALC.
- DONE:
  - out_valid=1; diff and bout are stable.
  - On an edge with out_ready=1, go to IDLE.
  - With out_ready=0, stay in DONE indefinitely and hold all outputs.
- diff and bout change only on the edge entering DONE. At all other times they hold the last result, or 0 after reset.
- in_ready, out_valid and busy are decoded from the state register only, with no combinational path from any input.
- Reset (rst_n low, asynchronous, at any time including mid-CALC or in DONE):
  - state=IDLE, diff=0, bout=0, counter=0, internal shift registers=0.
  - Resulting outputs: in_ready=1, out_valid=0, busy=0.
  - Any in-flight operation is discarded and produces no out_valid.
- Arithmetic identity: diff + b + bin = a + bout·2^WIDTH, exactly.

## Timing
- Accept edge E0.
- CALC spans edges E1..EWIDTH.
- out_valid is high starting in the cycle after edge EWIDTH, so latency is WIDTH+1 edges from acceptance to visible result. For WIDTH=3 that is 4 edges.
- With out_ready held high, the output handshake occurs at E(WIDTH+1) and the next accept can occur at E(WIDTH+2). Maximum throughput is one operation per WIDTH+2 cycles.
- No accept while busy: in_valid held high during CALC/DONE causes no capture, and exactly one operation is started per IDLE visit.
- The first edge after rst_n deasserts may accept if in_valid=1.

## Test plan
- Basic, a=5, b=3, bin=0: out_valid rises 4 edges after accept with diff=2, bout=0. Then a=3, b=5, bin=0 gives diff=6, bout=1.
- Borrow-in corners:
  - a=0, b=0, bin=1 → diff=7, bout=1.
  - a=7, b=7, bin=1 → diff=7, bout=1.
  - a=4, b=0, bin=1 → diff=3, bout=0.
  - a=7, b=0, bin=0 → diff=7, bout=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE. out_valid, diff and bout stay constant and in_ready stays 0. Raise out_ready; state returns to IDLE on the next edge and in_ready=1.
- Input isolation: change a and b and toggle in_valid during CALC. The result still matches the values captured at accept, and no second operation starts.
- Reset mid-CALC: assert rst_n low after bit 1 of a=6, b=1. Immediately (asynchronously) in_ready=1, out_valid=0, diff=0, bout=0. After release, a fresh a=6, b=1, bin=0 gives diff=5, bout=0.
- Exhaustive random back-to-back run, all 128 combinations with out_ready randomised:
  - Scoreboard checks diff and bout against the formula.
  - full_adder_3bit(diff, b, bin) must return sum=a and cout=bout.
  - Spacing between accepts is ≥ WIDTH+2 cycles.

Source files
------------

// File: rtl/serial_subtractor_3bit.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor_3bit
// Brief    : Bit-serial unsigned subtractor (a - b - bin), LSB-first, with
//            valid/ready handshakes on operand input and result output.
// Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor_3bit #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_bin,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_bout,
    output logic             o_busy
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_br;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;

    logic             w_last;
    logic             w_d;
    logic             w_br_nxt;
    logic [WIDTH-1:0] w_acc_nxt;

    assign w_last   = (r_cnt == C_LAST);
    assign w_d      = r_a[0] ^ r_b[0] ^ r_br;
    assign w_br_nxt = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);

    // Result bits enter at the MSB and shift down, so after WIDTH steps
    // bit 0 holds the first (LSB) difference bit.
    generate
        if (WIDTH > 1) begin : g_acc_wide
            assign w_acc_nxt = {w_d, r_acc[WIDTH-1:1]};
        end else begin : g_acc_narrow
            assign w_acc_nxt = w_d;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        o_in_ready  = 1'b0;
        o_out_valid = 1'b0;
        o_busy      = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_in_ready = 1'b1;
                if (i_in_valid) begin
                    w_state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                o_busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                o_busy      = 1'b1;
                o_out_valid = 1'b1;
                if (i_out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_br   <= 1'b0;
            r_cnt  <= '0;
            r_acc  <= '0;
            r_diff <= '0;
            r_bout <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_in_valid) begin
                        r_a   <= i_a;
                        r_b   <= i_b;
                        r_br  <= i_bin;
                        r_cnt <= '0;
                        r_acc <= '0;
                    end
                end
                S_CALC: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_br  <= w_br_nxt;
                    r_acc <= w_acc_nxt;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_diff <= w_acc_nxt;
                        r_bout <= w_br_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_diff = r_diff;
    assign o_bout = r_bout;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor_3bit.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_subtractor_3bit
// Brief    : Directed and exhaustive self-checking bench for the serial
//            subtractor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor_3bit;

    localparam int WIDTH = 3;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    serial_subtractor_3bit #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_a         (a),
        .i_b         (b),
        .i_bin       (bin),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_diff      (diff),
        .o_bout      (bout),
        .o_busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [WIDTH:0] full_adder_3bit(input logic [WIDTH-1:0] x,
                                                       input logic [WIDTH-1:0] y,
                                                       input logic cin);
        return {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Directed operation: accept, measure latency, optionally hold in DONE, hand off.
    task automatic do_op(input string tag, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                         input logic tbin, input logic [WIDTH-1:0] ed, input logic eb,
                         input int hold);
        int n;
        a = ta; b = tb_; bin = tbin; in_valid = 1'b1; out_ready = 1'b0;
        check({tag, "_in_ready"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_latency"}, n, WIDTH);
        check({tag, "_diff"}, diff, ed);
        check({tag, "_bout"}, bout, eb);
        check({tag, "_busy"}, busy, 1);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, out_valid, 1);
            check({tag, "_hold_diff"}, diff, ed);
            check({tag, "_hold_bout"}, bout, eb);
            check({tag, "_hold_in_ready"}, in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_post_valid"}, out_valid, 0);
        check({tag, "_post_in_ready"}, in_ready, 1);
    endtask

    initial begin
        int n;
        int last_acc;
        logic [WIDTH-1:0] ea;
        logic [WIDTH-1:0] eb_;
        logic             ebin;
        logic [WIDTH:0]   ref_full;
        logic [WIDTH:0]   fa;

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; bin = 1'b0; out_ready = 1'b0;
        #1;
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_diff", diff, 0);
        check("reset_bout", bout, 0);
        @(negedge clk); rst_n = 1'b1;

        do_op("basic_5m3", 3'd5, 3'd3, 1'b0, 3'd2, 1'b0, 0);
        do_op("basic_3m5", 3'd3, 3'd5, 1'b0, 3'd6, 1'b1, 0);
        do_op("bin_000", 3'd0, 3'd0, 1'b1, 3'd7, 1'b1, 0);
        do_op("bin_771", 3'd7, 3'd7, 1'b1, 3'd7, 1'b1, 0);
        do_op("bin_401", 3'd4, 3'd0, 1'b1, 3'd3, 1'b0, 0);
        do_op("bp_700", 3'd7, 3'd0, 1'b0, 3'd7, 1'b0, 5);

        // Input isolation: operands and in_valid wiggle while computing.
        a = 3'd2; b = 3'd1; bin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < WIDTH; k++) begin
            a = 3'd7; b = 3'd0; bin = 1'b1; in_valid = k[0];
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        check("iso_valid", out_valid, 1);
        check("iso_diff", diff, 1);
        check("iso_bout", bout, 0);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("iso_no_second_op", busy, 0);
        check("iso_no_second_valid", out_valid, 0);

        // Reset after bit 1 of 6-1.
        a = 3'd6; b = 3'd1; bin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b0; #1;
        check("rst_mid_in_ready", in_ready, 1);
        check("rst_mid_out_valid", out_valid, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_diff", diff, 0);
        check("rst_mid_bout", bout, 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mid_no_valid", out_valid, 0);
        do_op("after_rst_6m1", 3'd6, 3'd1, 1'b0, 3'd5, 1'b0, 0);

        // Exhaustive back-to-back run with random backpressure.
        last_acc = -1000;
        for (int v = 0; v < 128; v++) begin
            ea = v[2:0]; eb_ = v[5:3]; ebin = v[6];
            a = ea; b = eb_; bin = ebin; in_valid = 1'b1;
            n = 0;
            while (!in_ready && n < 50) begin
                @(posedge clk); #1; n++;
            end
            check("ex_accept_timeout", (n < 50), 1);
            @(posedge clk);
            if (last_acc >= 0) check("ex_spacing", (cyc - last_acc) >= WIDTH + 2, 1);
            last_acc = cyc;
            #1;
            a = WIDTH'($urandom); b = WIDTH'($urandom); bin = 1'($urandom);
            n = 0;
            while (!out_valid && n < 20) begin
                @(posedge clk); #1; n++;
            end
            check("ex_latency", n, WIDTH);
            ref_full = {1'b0, ea} - {1'b0, eb_} - {{WIDTH{1'b0}}, ebin};
            check("ex_diff", diff, ref_full[WIDTH-1:0]);
            check("ex_bout", bout, ({1'b0, ea} < ({1'b0, eb_} + {{WIDTH{1'b0}}, ebin})));
            fa = full_adder_3bit(diff, eb_, ebin);
            check("ex_adder_identity", fa, {bout, ea});
            n = 0;
            do begin
                out_ready = (n >= 8) ? 1'b1 : 1'($urandom_range(0, 1));
                @(posedge clk); #1; n++;
            end while (out_valid && n < 20);
            out_ready = 1'b0;
            check("ex_handoff", out_valid, 0);
        end
        in_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
